aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencer for the AES encryption round datapath.
- Accepts a start request with a key-length select and fetches round keys from the key schedule through a ready handshake.
- Drives the datapath through the initial AddRoundKey, Nr-1 full rounds and a final round with no MixColumns, then pulses done.
- Sits between the GCM top-level control and the AES round/key-expansion datapath.

Parameters:
- CNT_SIZE, 4: width of the round index; must hold 14.
- NR_128, 10: round count for a 128-bit key.
- NR_192, 12: round count for a 192-bit key.
- NR_256, 14: round count for a 256-bit key.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request; accepted only when o_ready=1.
- i_key_len  input  2  key length: 0=128, 1=192, 2=256, 3=illegal; sampled when start is accepted.
- i_ks_ready  input  1  key schedule presents the round key for o_round this cycle.
- i_abort  input  1  abort request; present only with AES_RND_CTRL_ABORT_EN.
- o_ready  output  1  idle, can accept start.
- o_busy  output  1  operation in progress.
- o_round  output  CNT_SIZE  current round index 0..Nr.
- o_rk_req  output  1  requests the round key for o_round.
- o_load  output  1  datapath loads state = plaintext XOR rk0.
- o_round_en  output  1  datapath applies one round with the current key.
- o_final  output  1  qualifies o_round_en; skip MixColumns.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  one-cycle pulse on illegal key length.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except o_ready=1. State is IDLE, o_round=0, latched Nr=10.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- Output decode is combinational from state, except o_err, which is registered.
- IDLE:
  - o_ready=1.
  - i_start=1 with i_key_len in 0..2: latch Nr, o_round<=0, go to INIT.
  - i_start=1 with i_key_len=3: o_err=1 next cycle, stay in IDLE, Nr unchanged.
  - i_start is ignored in every other state; no queuing.
- INIT:
  - o_busy=1, o_rk_req=1.
  - When i_ks_ready=1: o_load=1 that cycle, o_round<=1, go to ROUND.
  - When i_ks_ready=0: hold; no strobes asserted.
- ROUND:
  - o_busy=1, o_rk_req=1.
  - When i_ks_ready=1: o_round_en=1.
    - If o_round==Nr-1: o_round<=Nr, go to FINAL.
    - Otherwise: o_round<=o_round+1.
  - When i_ks_ready=0: stall with o_round held.
- FINAL:
  - o_busy=1, o_rk_req=1.
  - When i_ks_ready=1: o_round_en=1 and o_final=1, go to DONE.
- DONE:
  - o_busy=1, o_done=1 for one cycle, o_round<=0, then go to IDLE.
  - o_ready returns to 1 the following cycle; no back-to-back start in DONE.
- Latency: with i_ks_ready held at 1, o_done asserts Nr+2 cycles after the start-accept edge (12 for AES-128, 16 for AES-256).
- Strobe count: exactly Nr o_round_en pulses and one o_load per operation. o_final coincides only with the Nr-th o_round_en.
- Width rule: o_round never exceeds Nr and never wraps; no compare beyond 4 bits.
- Reset mid-operation: immediate return to the reset values; no o_done.

Optional Feature:
- Macro: AES_RND_CTRL_ABORT_EN.
- Defined:
  - i_abort port exists.
  - i_abort=1 in INIT, ROUND, FINAL or DONE forces IDLE and o_round=0 next cycle.
  - No o_done; any o_done pending in DONE is suppressed.
  - Abort has priority over i_ks_ready in the same cycle; strobes still assert combinationally that cycle.
  - i_abort is ignored in IDLE.
- Undefined: no i_abort port; behaviour exactly as above.

Decomposition:
- Package aes_pkg holds:
  - key-length encodings KEY_128, KEY_192, KEY_256, KEY_BAD;
  - constants NR_128, NR_192, NR_256;
  - the FSM state enum.
- One sub-module, aes_rnd_idx: a CNT_SIZE-bit round index register with clear, enable-increment and terminal flag (idx==limit-1). Instantiated once.

Test Plan:
1. Key 128, i_ks_ready=1 always, start pulse -> o_load at cycle 1, o_round_en in cycles 2..11, o_final in cycle 11 with o_round=10, o_done in cycle 12, o_ready=1 in cycle 13.
2. Key 256, i_ks_ready toggling 1,0,1,0 -> 14 o_round_en pulses, o_round holds during every 0 cycle, o_done after all 14 rounds.
3. i_key_len=3 with start -> o_err pulse in cycle 1, o_busy stays 0, no o_load; a following start with key 192 -> 12 rounds.
4. i_start asserted during ROUND with key 256 -> ignored; the current 128-bit operation completes with exactly 10 rounds.
5. rst_n low at round 5, then release -> all outputs at reset values; next start runs a full clean sequence.
6. With AES_RND_CTRL_ABORT_EN, i_abort at round 4 with i_ks_ready=1 -> IDLE next cycle, no o_done, o_ready=1, next start runs normally.

Source files
------------

// File: rtl/aes_pkg.sv
// AES round sequencer shared types: key-length codes, round counts, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_BAD = 2'd3
    } key_len_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Round count for a legal key-length code; the illegal code never reaches here.
    function automatic int nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_192: nr_of = NR_192;
            KEY_256: nr_of = NR_256;
            default: nr_of = NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bundle between GCM control / key schedule (master) and the round sequencer (slave).
// Latency: n/a (wiring only).
// Backpressure: key schedule stalls the sequencer by holding i_ks_ready low.
// Optional: i_abort exists only when AES_RND_CTRL_ABORT_EN is defined.
interface aes_round_ctrl_if #(
    parameter int CNT_SIZE = 4
);
    logic                i_start;
    logic [1:0]          i_key_len;
    logic                i_ks_ready;
`ifdef AES_RND_CTRL_ABORT_EN
    logic                i_abort;
`endif
    logic                o_ready;
    logic                o_busy;
    logic [CNT_SIZE-1:0] o_round;
    logic                o_rk_req;
    logic                o_load;
    logic                o_round_en;
    logic                o_final;
    logic                o_done;
    logic                o_err;

    modport master (
        output i_start, i_key_len, i_ks_ready,
`ifdef AES_RND_CTRL_ABORT_EN
        output i_abort,
`endif
        input  o_ready, o_busy, o_round, o_rk_req, o_load, o_round_en,
               o_final, o_done, o_err
    );

    modport slave (
        input  i_start, i_key_len, i_ks_ready,
`ifdef AES_RND_CTRL_ABORT_EN
        input  i_abort,
`endif
        output o_ready, o_busy, o_round, o_rk_req, o_load, o_round_en,
               o_final, o_done, o_err
    );

endinterface

// File: rtl/aes_rnd_idx.sv
// Round index register: clear, increment, terminal flag at idx == limit-1.
// Latency: idx updates on the clock edge after clr/inc; term is combinational.
// Backpressure: none; holds when neither clr nor inc is asserted.
// Ports: clk, rst_n, clr (priority over inc), inc, limit, idx, term.
module aes_rnd_idx #(
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    input  logic [CNT_SIZE-1:0] limit,
    output logic [CNT_SIZE-1:0] idx,
    output logic                term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + CNT_SIZE'(1);
        end
    end

    assign term = (idx == (limit - CNT_SIZE'(1)));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: initial AddRoundKey, Nr-1 full rounds, final round, done pulse.
// Latency: o_done Nr+2 cycles after start accept when the key schedule never stalls.
// Backpressure: every key-consuming step waits on i_ks_ready; i_start accepted only while o_ready.
// Ports: clk, rst_n (async active-low), bus (aes_round_ctrl_if.slave: start/key_len/ks_ready in,
//        ready/busy/round/rk_req/load/round_en/final/done/err out).
// Optional: AES_RND_CTRL_ABORT_EN adds i_abort, which returns any non-idle state to IDLE.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int CNT_SIZE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_round_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic [CNT_SIZE-1:0] nr_q;
    logic                err_q;
    logic [CNT_SIZE-1:0] idx;
    logic                idx_clr, idx_inc, idx_term;
    logic                start_ok, start_bad, abort;
    logic                ready, busy, rk_req, load, round_en, fin_rnd, done;

`ifdef AES_RND_CTRL_ABORT_EN
    assign abort = bus.i_abort;
`else
    assign abort = 1'b0;
`endif

    assign start_ok  = (state_q == ST_IDLE) && bus.i_start && (bus.i_key_len != KEY_BAD);
    assign start_bad = (state_q == ST_IDLE) && bus.i_start && (bus.i_key_len == KEY_BAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            nr_q    <= CNT_SIZE'(NR_128);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= start_bad;
            if (start_ok) begin
                nr_q <= CNT_SIZE'(nr_of(bus.i_key_len));
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        ready    = 1'b0;
        busy     = 1'b0;
        rk_req   = 1'b0;
        load     = 1'b0;
        round_en = 1'b0;
        fin_rnd  = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start_ok) begin
                    idx_clr = 1'b1;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                busy   = 1'b1;
                rk_req = 1'b1;
                if (bus.i_ks_ready) begin
                    load    = 1'b1;
                    idx_inc = 1'b1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy   = 1'b1;
                rk_req = 1'b1;
                if (bus.i_ks_ready) begin
                    round_en = 1'b1;
                    idx_inc  = 1'b1;
                    // Increment lands exactly on Nr, which is the final round's index.
                    if (idx_term) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                busy   = 1'b1;
                rk_req = 1'b1;
                if (bus.i_ks_ready) begin
                    round_en = 1'b1;
                    fin_rnd  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = !abort;
                idx_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over key-ready; strobes decoded above still show this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_clr = 1'b1;
            idx_inc = 1'b0;
        end
    end

    aes_rnd_idx #(
        .CNT_SIZE (CNT_SIZE)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (idx_clr),
        .inc   (idx_inc),
        .limit (nr_q),
        .idx   (idx),
        .term  (idx_term)
    );

    assign bus.o_ready    = ready;
    assign bus.o_busy     = busy;
    assign bus.o_round    = idx;
    assign bus.o_rk_req   = rk_req;
    assign bus.o_load     = load;
    assign bus.o_round_en = round_en;
    assign bus.o_final    = fin_rnd;
    assign bus.o_done     = done;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for the AES round sequencer: directed and randomized operations against a key-consumption model.
// Latency: n/a.
// Backpressure: i_ks_ready driven always-on, toggling or random.
module tb_aes_round_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    aes_round_ctrl_if #(.CNT_SIZE(4)) bus ();

    aes_round_ctrl #(.CNT_SIZE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: ready busy rk_req load round_en final done err round[3:0]
    function automatic logic [11:0] obs();
        return {bus.o_ready, bus.o_busy, bus.o_rk_req, bus.o_load, bus.o_round_en,
                bus.o_final, bus.o_done, bus.o_err, bus.o_round};
    endfunction

    function automatic logic [11:0] mk(bit rdy, bit bsy, bit req, bit ld, bit en,
                                       bit fn, bit dn, bit er, int rnd);
        logic [3:0] r;
        r = 4'(rnd);
        return {rdy, bsy, req, ld, en, fn, dn, er, r};
    endfunction

    function automatic int nr_ref(logic [1:0] key);
        case (key)
            2'd0:    return 10;
            2'd1:    return 12;
            default: return 14;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    // One operation. The model: the request index k runs 0..Nr; each cycle with
    // i_ks_ready consumes key k (k=0 load, k>0 round_en, k=Nr also final), then one done cycle.
    // mode: 0 always ready, 1 toggle 1,0,..., 2 random. *_k = -1 disables the event.
    task automatic run_op(input logic [1:0] key, input int mode, input int mid_start_k,
                          input int rst_k, input int abort_k);
        int   nr, k, cyc, ens;
        bit   ks, fin;
        nr = nr_ref(key);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_key_len = key; bus.i_ks_ready = 1'b0;
        #1 chk("pre_start_idle", obs(), mk(1,0,0,0,0,0,0,0,0));
        k = 0; cyc = 0; ens = 0; fin = 0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0; bus.i_key_len = 2'd0;
            if (k == mid_start_k) begin
                bus.i_start = 1'b1; bus.i_key_len = 2'd2;
            end
            case (mode)
                0:       ks = 1'b1;
                1:       ks = (cyc % 2 == 1);
                default: ks = ($urandom_range(0, 3) != 0);
            endcase
            if (k == abort_k) ks = 1'b1;
            bus.i_ks_ready = ks;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1 chk("mid_reset", obs(), mk(1,0,0,0,0,0,0,0,0));
                @(negedge clk);
                rst_n = 1'b1;
                #1 chk("after_reset", obs(), mk(1,0,0,0,0,0,0,0,0));
                return;
            end
`ifdef AES_RND_CTRL_ABORT_EN
            if (k == abort_k) begin
                bus.i_abort = 1'b1;
                #1 chk("abort_cycle", obs(), mk(0,1,1,k==0,k>0,k==nr,0,0,k));
                @(negedge clk);
                bus.i_abort = 1'b0; bus.i_ks_ready = 1'b1;
                #1 chk("after_abort", obs(), mk(1,0,0,0,0,0,0,0,0));
                return;
            end
`endif
            #1;
            if (k <= nr) begin
                chk("step", obs(), mk(0,1,1, ks && k == 0, ks && k > 0, ks && k == nr, 0,0, k));
                if (ks && k > 0) ens++;
                if (ks) k++;
            end else begin
                chk("done", obs(), mk(0,1,0,0,0,0,1,0,nr));
                fin = 1;
            end
        end
        chk("finished_in_budget", 32'(fin), 32'd1);
        chk("round_en_count", 32'(ens), 32'(nr));
        if (mode == 0) chk("latency", 32'(cyc), 32'(nr + 2));
        @(negedge clk);
        bus.i_start = 1'b0;
        #1 chk("back_idle", obs(), mk(1,0,0,0,0,0,0,0,0));
    endtask

    task automatic bad_key();
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_key_len = 2'd3; bus.i_ks_ready = 1'b1;
        #1 chk("bad_accept", obs(), mk(1,0,0,0,0,0,0,0,0));
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_key_len = 2'd0;
        #1 chk("bad_err", obs(), mk(1,0,0,0,0,0,0,1,0));
        @(negedge clk);
        #1 chk("bad_err_clear", obs(), mk(1,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        total = 0; passed = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_key_len = 2'd0; bus.i_ks_ready = 1'b0;
`ifdef AES_RND_CTRL_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        #3 chk("reset_state", obs(), mk(1,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd0, 0, -1, -1, -1);   // AES-128, no stalls
        run_op(2'd2, 1, -1, -1, -1);   // AES-256, toggling key ready
        bad_key();
        run_op(2'd1, 0, -1, -1, -1);   // AES-192 after illegal key
        run_op(2'd0, 0, 3, -1, -1);    // start during ROUND is ignored
        run_op(2'd0, 0, -1, 5, -1);    // reset at round 5
        run_op(2'd0, 0, -1, -1, -1);   // clean run after reset
`ifdef AES_RND_CTRL_ABORT_EN
        run_op(2'd2, 0, -1, -1, 4);    // abort at round 4
        run_op(2'd0, 0, -1, -1, -1);
`endif
        for (int i = 0; i < 6; i++) begin
            logic [1:0] key;
            key = 2'($urandom_range(0, 3));
            if (key == 2'd3) bad_key();
            else run_op(key, 2, -1, -1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
